// File: rtl/tdm_demux16_pkg.sv
// tdm_pkg: frame geometry and receiver state shared with the transmit-side serialiser
package tdm_pkg;
  localparam int N_CH = 16;
  localparam int SEL_W = $clog2(N_CH);
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/tdm_demux16_if.sv
// tdm_demux16_if: serial slot stream in, rebuilt word and status pulses out
interface tdm_demux16_if;
  import tdm_pkg::*;
  logic din;
  logic din_valid;
  logic sof;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0] dout;
  logic dout_valid;
  logic frame_err;
  modport master(output din, din_valid, sof, input sel, dout, dout_valid, frame_err);
  modport slave(input din, din_valid, sof, output sel, dout, dout_valid, frame_err);
endinterface

// File: rtl/tdm_demux16_slot_counter.sv
// slot_counter: slot index with load-to-1, clear, increment and last-slot flag
module slot_counter
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load1,
  input  logic             clr,
  input  logic             inc,
  output logic [SEL_W-1:0] cnt,
  output logic             tc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load1) cnt <= SEL_W'(1);
    else if (inc) cnt <= cnt + 1'b1;
  assign tc = cnt == SEL_W'(N_CH - 1);
endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16: rebuilds a word from one serial bit per valid slot, slot k -> bit k
module tdm_demux16
  import tdm_pkg::*;
(
  input logic clk,
  input logic rst,
  tdm_demux16_if.slave bus
);
  state_t state, state_nx;
  logic [N_CH-2:0] shadow;
  logic [SEL_W-1:0] cnt;
  logic start, run_bit, done, abort, inc, tc;
  slot_counter u_cnt (
    .clk(clk), .rst(rst), .load1(start), .clr(done), .inc(inc), .cnt(cnt), .tc(tc)
  );
  always_comb begin
    start = bus.din_valid && bus.sof;
    run_bit = bus.din_valid && !bus.sof && state == RUN;
    done = run_bit && tc;
    inc = run_bit && !tc;
    abort = start && state == RUN;
    state_nx = start ? RUN : done ? IDLE : state;
  end
  // the last slot bit bypasses the shadow and goes straight into dout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shadow <= '0;
      bus.dout <= '0;
      bus.dout_valid <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) shadow[0] <= bus.din;
      else if (inc) shadow[cnt] <= bus.din;
      if (done) bus.dout <= {bus.din, shadow};
      bus.dout_valid <= done;
      bus.frame_err <= abort;
    end
  assign bus.sel = cnt;
endmodule
